t9990_palette: RTL
==================

T9990_PALETTE -- requirements
Module: t9990_palette

Interface
REQ-001 The block SHALL use a single clock CLK and an asynchronous active-low reset RESET_n; no other clock or reset SHALL exist.
REQ-002 Ports SHALL be as follows:
- RESET_n  in  1  async active-low reset
- CLK  in  1  system clock
- DCLK_EN  in  1  dot-clock enable; video pipeline advances only when high
- PA  in  6  palette address from priority mixer
- PRI  in  1  priority flag from mixer (1 = backdrop)
- PTR_WR  in  1  one-CLK strobe: load palette pointer
- PTR_IN  in  8  pointer value; [7:2] entry, [1:0] component (0=R, 1=G, 2=B)
- PTR_OUT  out  8  current pointer
- DATA_WR  in  1  one-CLK strobe: CPU palette data write
- DATA_RD  in  1  one-CLK strobe: CPU palette data read
- DATA_IN  in  8  write data; R byte: [7]=YS, [4:0]=R; G/B byte: [4:0]
- DATA_OUT  out  8  read data, registered
- AUTOINC_DIS  in  1  1 = pointer does not advance after DATA_WR/DATA_RD
- VID_R, VID_G, VID_B  out  5 each  colour components
- VID_YS  out  1  superimpose bit of looked-up entry
- VID_PRI  out  1  PRI delayed to align with colour

Function
REQ-003 Storage SHALL be 64 entries x 16 bits (YS, R5, G5, B5), implemented as registers, readable by video and CPU in the same cycle.
REQ-004 Video path SHALL be a 2-stage pipeline advanced only on DCLK_EN: stage 1 registers PA and PRI; stage 2 registers the entry at the stage-1 address onto VID_* together with the stage-1 PRI.
REQ-005 Latency SHALL be exactly 2 DCLK_EN pulses from PA/PRI sample to VID_* update; VID_* SHALL hold when DCLK_EN is low.
REQ-006 CPU writes SHALL be atomic per entry: DATA_WR at component 0 latches R byte (YS, R) into a staging register; component 1 latches G into staging; component 2 writes {staged YS, staged R, staged G, DATA_IN[4:0]} into the entry at pointer[7:2].
REQ-007 A DATA_WR at component 3 SHALL write nothing.
REQ-008 DATA_RD SHALL load DATA_OUT on the following CLK edge with the addressed component of the stored entry ({YS,2'b00,R}, {3'b000,G}, {3'b000,B}; component 3 returns 8'h00); staging registers SHALL NOT be returned.
REQ-009 When AUTOINC_DIS=0, each DATA_WR or DATA_RD SHALL advance the pointer: component 0->1->2, and 2 or 3 -> component 0 of entry+1; entry 63 wraps to 0.
REQ-010 When AUTOINC_DIS=1 the pointer SHALL be unchanged by data accesses.
REQ-011 PTR_WR SHALL load the pointer from PTR_IN and SHALL take precedence over a same-cycle advance; the data access in that cycle SHALL use the old pointer.
REQ-012 DATA_WR and DATA_RD asserted together SHALL perform the write only and advance once.
REQ-013 A CPU entry write and a video stage-2 read of the same entry in the same CLK SHALL deliver the old value to VID_*; the new value is visible from the next DCLK_EN.
REQ-014 CPU accesses SHALL be independent of DCLK_EN.

Reset
REQ-015 On RESET_n low: all 64 entries, staging registers, pointer, DATA_OUT, VID_R/G/B, VID_YS SHALL be 0; VID_PRI and stage-1 PRI SHALL be 1; stage-1 PA SHALL be 0.
REQ-016 Reset asserted mid-sequence (after R or G byte) SHALL discard the staged bytes; no entry write SHALL occur.

Verification
REQ-017 Bench SHALL cover:
- PTR 8'h14 (entry 5, comp 0), write 8'h9F, 8'h0A, 8'h15 -> entry 5 = YS1 R31 G10 B21; PTR_OUT=8'h18; PA=5 with DCLK_EN -> VID = 31/10/21, YS=1 after 2 DCLK_EN.
- Write R,G to entry 7 then read VID for PA=7 -> unchanged (0/0/0) until B byte written.
- PTR 8'hFE, write B byte -> entry 63 updated, PTR_OUT=8'h00 (wrap); with AUTOINC_DIS=1 repeated writes leave PTR_OUT fixed.
- PTR 8'h17 (comp 3), DATA_WR -> no entry change, PTR_OUT=8'h18; DATA_RD at comp 3 -> DATA_OUT=8'h00.
- DCLK_EN every 3rd CLK, PA sweep 0..63, PRI toggling -> VID_PRI/colour aligned, exactly 2 enables latency, hold between enables.
- RESET_n pulse after R byte, then G,B writes from comp 0 pointer -> entry reflects only post-reset bytes; all outputs at REQ-015 values during reset.

Source files
------------

// File: rtl/t9990_palette.sv
// T9990 colour palette: 64-entry register file with a two-stage
// video lookup pipeline and an auto-incrementing CPU access port.
module t9990_palette (
  input  logic       RESET_n,
  input  logic       CLK,
  input  logic       DCLK_EN,
  input  logic [5:0] PA,
  input  logic       PRI,
  input  logic       PTR_WR,
  input  logic [7:0] PTR_IN,
  output logic [7:0] PTR_OUT,
  input  logic       DATA_WR,
  input  logic       DATA_RD,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  input  logic       AUTOINC_DIS,
  output logic [4:0] VID_R,
  output logic [4:0] VID_G,
  output logic [4:0] VID_B,
  output logic       VID_YS,
  output logic       VID_PRI
);

  logic [15:0] pal_q [64];
  logic [15:0] pal_d [64];

  logic [7:0]  ptr_q, ptr_d;
  logic        stg_ys_q, stg_ys_d;
  logic [4:0]  stg_r_q, stg_r_d;
  logic [4:0]  stg_g_q, stg_g_d;
  logic [7:0]  dout_q, dout_d;

  logic [5:0]  s1_pa_q, s1_pa_d;
  logic        s1_pri_q, s1_pri_d;
  logic [15:0] vid_q, vid_d;
  logic        vid_pri_q, vid_pri_d;

  logic [1:0]  comp;
  logic [5:0]  ent;
  logic [5:0]  ent_nxt;
  logic [15:0] cur;
  logic        rd_only;
  logic        access;
  logic        unused_din;

  assign comp    = ptr_q[1:0];
  assign ent     = ptr_q[7:2];
  assign ent_nxt = ent + 6'd1;
  assign cur     = pal_q[ent];
  assign rd_only = DATA_RD & ~DATA_WR;
  assign access  = DATA_WR | DATA_RD;

  assign unused_din = ^DATA_IN[6:5];

  always_comb begin
    pal_d    = pal_q;
    stg_ys_d = stg_ys_q;
    stg_r_d  = stg_r_q;
    stg_g_d  = stg_g_q;
    dout_d   = dout_q;
    ptr_d    = ptr_q;

    // entry is committed only on the B byte, keeping updates atomic
    if (DATA_WR) begin
      case (comp)
        2'd0: begin
          stg_ys_d = DATA_IN[7];
          stg_r_d  = DATA_IN[4:0];
        end
        2'd1: stg_g_d = DATA_IN[4:0];
        2'd2: pal_d[ent] = {stg_ys_q, stg_r_q,
                            stg_g_q, DATA_IN[4:0]};
        default: ;
      endcase
    end

    if (rd_only) begin
      case (comp)
        2'd0:    dout_d = {cur[15], 2'b00, cur[14:10]};
        2'd1:    dout_d = {3'b000, cur[9:5]};
        2'd2:    dout_d = {3'b000, cur[4:0]};
        default: dout_d = 8'h00;
      endcase
    end

    if (PTR_WR) begin
      ptr_d = PTR_IN;
    end else if (access && !AUTOINC_DIS) begin
      if (comp[1]) begin
        ptr_d = {ent_nxt, 2'b00};
      end else begin
        ptr_d = ptr_q + 8'd1;
      end
    end
  end

  always_comb begin
    s1_pa_d   = s1_pa_q;
    s1_pri_d  = s1_pri_q;
    vid_d     = vid_q;
    vid_pri_d = vid_pri_q;
    if (DCLK_EN) begin
      s1_pa_d   = PA;
      s1_pri_d  = PRI;
      vid_d     = pal_q[s1_pa_q];
      vid_pri_d = s1_pri_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < 64; i++) begin
        pal_q[i] <= '0;
      end
      ptr_q     <= '0;
      stg_ys_q  <= 1'b0;
      stg_r_q   <= '0;
      stg_g_q   <= '0;
      dout_q    <= '0;
      s1_pa_q   <= '0;
      s1_pri_q  <= 1'b1;
      vid_q     <= '0;
      vid_pri_q <= 1'b1;
    end else begin
      pal_q     <= pal_d;
      ptr_q     <= ptr_d;
      stg_ys_q  <= stg_ys_d;
      stg_r_q   <= stg_r_d;
      stg_g_q   <= stg_g_d;
      dout_q    <= dout_d;
      s1_pa_q   <= s1_pa_d;
      s1_pri_q  <= s1_pri_d;
      vid_q     <= vid_d;
      vid_pri_q <= vid_pri_d;
    end
  end

  assign PTR_OUT  = ptr_q;
  assign DATA_OUT = dout_q;
  assign VID_YS   = vid_q[15];
  assign VID_R    = vid_q[14:10];
  assign VID_G    = vid_q[9:5];
  assign VID_B    = vid_q[4:0];
  assign VID_PRI  = vid_pri_q;

endmodule
